branch_tag_allocator: RTL
=========================

# branch_tag_allocator

Dispatch-side writer for the branch stack: assigns one-hot branch tags (b_mask bits) to dispatching branches/jumps, builds the per-tag checkpoint entry fields, and supplies the next-cycle b_mask the branch stack registers. Tracks live tags across resolve, mispredict restore, and squash. Sits between decode/rename and the branch stack, alongside the ROB tail logic. Map-table and free-list snapshot fields are merged by rename and are outside this block.

## Interface
- B_MASK_WIDTH, 4, number of tags (branch stack entries)
- DISPATCH_WIDTH, 2, instructions offered per cycle, slot 0 oldest
- ROB_SZ_BITS, 5, ROB index width
- CNT_BITS, $clog2(B_MASK_WIDTH+1), free-tag count width
- clock  in  1  clock
- reset  in  1  synchronous, active-high
- dispatch_valid  in  DW  slot holds an instruction
- dispatch_is_branch  in  DW  slot is a conditional branch or jump
- dispatch_is_jump  in  DW  slot is a jump (subset of is_branch)
- dispatch_PC  in  DW×32  instruction PC
- dispatch_recovery_PC  in  DW×32  alternate-path PC (predicted target for jumps)
- dispatch_rob_tail  in  DW×ROB_SZ_BITS  ROB tail after this instruction
- resolve_mask  in  BW  one-hot or zero; tag resolving this cycle (branch stack b_mm_out)
- restore_valid  in  1  resolving tag mispredicted
- surviving_mask  in  BW  branch stack b_mask_combinational (valid with restore_valid)
- dispatch_ok  out  DW  slot may dispatch this cycle (prefix: once 0, all younger 0)
- alloc_tag  out  DW×BW  one-hot tag for slot; 0 for non-branch or not ok
- inst_b_mask  out  DW×BW  tags the slot depends on
- entry_write  out  BW  tag entry written this cycle
- entry_b_m, entry_PC, entry_recovery_PC, entry_rob_tail, entry_is_jump  out  per tag  entry fields, 0 where entry_write=0
- next_b_mask  out  BW  live-tag set for next cycle
- free_tag_count  out  CNT_BITS  popcount(~b_mask_reg)
- full_stall_cycles  out  32  cycles with a valid branch blocked for lack of tags

## Operation
- State: b_mask_reg (live tags), full_stall_cycles counter.
- Allocation pool = ~b_mask_reg only; tags freed this cycle are not reusable until next cycle (prevents write/clear collision in branch stack).
- Walk slots oldest first; each valid branch takes lowest-index free pool tag. First branch finding pool empty: its dispatch_ok=0 and all younger slots 0. Non-branch slots before it: ok=1.
- restore_valid=1: all dispatch_ok=0, no allocation, entry_write=0 (wrong-path fetch).
- inst_b_mask[s] = (b_mask_reg & ~resolve_mask) | alloc_tag of all older ok slots in same cycle; a branch's own tag excluded. Cleared to 0 when dispatch_ok[s]=0.
- For allocated tag t from slot s: entry_write[t]=1, entry_b_m[t]=inst_b_mask[s], other fields copied from slot s.
- next_b_mask: restore_valid → surviving_mask & ~resolve_mask; else (b_mask_reg & ~resolve_mask) | OR of alloc_tag.
- Resolving a tag not in b_mask_reg: ignored.
- full_stall_cycles increments (saturates at 2^32-1) when any valid branch slot has dispatch_ok=0 and restore_valid=0.

## Timing
- All outputs except next-state registers are combinational from b_mask_reg and inputs, same cycle.
- b_mask_reg <= next_b_mask each cycle; allocated tag is live and visible in free_tag_count next cycle.
- Resolve in cycle N: tag reusable in cycle N+1.
- Reset: b_mask_reg=0, full_stall_cycles=0; free_tag_count=BW; with no input activity all other outputs 0 and dispatch_ok follows valid slots (all ok).
- Reset mid-operation discards live tags; no entry_write in reset cycle.

## Test plan
- After reset, slots {branch, branch} valid → alloc_tag 0001/0010, inst_b_mask 0000/0001, entry_b_m[1]=0001, next_b_mask 0011.
- b_mask_reg=1110, slots {branch, branch} → slot0 tag 0001, dispatch_ok=01, full_stall_cycles +1; next_b_mask 1111.
- b_mask_reg=1111, resolve_mask=0010 no restore, slot0 branch → stalled this cycle (ok=00), next_b_mask 1101; next cycle gets tag 0010.
- b_mask_reg=0111, resolve 0001 with restore, surviving_mask 0001 → dispatch_ok=00, entry_write=0, next_b_mask 0000.
- b_mask_reg=0011, resolve 0001 no restore, slots {ALU, branch} → inst_b_mask 0010/0010, alloc 0100, entry_b_m[2]=0010, next 0110.
- Reset asserted with b_mask_reg=1111 and stalled counter 7 → next cycle b_mask_reg 0, counter 0, free_tag_count 4.

Source files
------------

// File: rtl/branch_tag_allocator.sv
// Branch tag allocator: hands out one-hot branch tags to dispatching branches,
// builds the per-tag checkpoint entry fields and tracks the live-tag set.
module branch_tag_allocator #(
   parameter int unsigned B_MASK_WIDTH   = 4,
   parameter int unsigned DISPATCH_WIDTH = 2,
   parameter int unsigned ROB_SZ_BITS    = 5,
   parameter int unsigned CNT_BITS       = $clog2(B_MASK_WIDTH + 1)
) (
   input  logic                                         clock,
   input  logic                                         reset,
   input  logic [DISPATCH_WIDTH-1:0]                    dispatch_valid_i,
   input  logic [DISPATCH_WIDTH-1:0]                    dispatch_is_branch_i,
   input  logic [DISPATCH_WIDTH-1:0]                    dispatch_is_jump_i,
   input  logic [DISPATCH_WIDTH-1:0][31:0]              dispatch_PC_i,
   input  logic [DISPATCH_WIDTH-1:0][31:0]              dispatch_recovery_PC_i,
   input  logic [DISPATCH_WIDTH-1:0][ROB_SZ_BITS-1:0]   dispatch_rob_tail_i,
   input  logic [B_MASK_WIDTH-1:0]                      resolve_mask_i,
   input  logic                                         restore_valid_i,
   input  logic [B_MASK_WIDTH-1:0]                      surviving_mask_i,
   output logic [DISPATCH_WIDTH-1:0]                    dispatch_ok_o,
   output logic [DISPATCH_WIDTH-1:0][B_MASK_WIDTH-1:0]  alloc_tag_o,
   output logic [DISPATCH_WIDTH-1:0][B_MASK_WIDTH-1:0]  inst_b_mask_o,
   output logic [B_MASK_WIDTH-1:0]                      entry_write_o,
   output logic [B_MASK_WIDTH-1:0][B_MASK_WIDTH-1:0]    entry_b_m_o,
   output logic [B_MASK_WIDTH-1:0][31:0]                entry_PC_o,
   output logic [B_MASK_WIDTH-1:0][31:0]                entry_recovery_PC_o,
   output logic [B_MASK_WIDTH-1:0][ROB_SZ_BITS-1:0]     entry_rob_tail_o,
   output logic [B_MASK_WIDTH-1:0]                      entry_is_jump_o,
   output logic [B_MASK_WIDTH-1:0]                      next_b_mask_o,
   output logic [CNT_BITS-1:0]                          free_tag_count_o,
   output logic [31:0]                                  full_stall_cycles_o
);

   logic [B_MASK_WIDTH-1:0] b_mask_q, b_mask_d;
   logic [31:0]             stall_cnt_q, stall_cnt_d;

   logic [B_MASK_WIDTH-1:0] pool;     // tags still free for younger slots
   logic [B_MASK_WIDTH-1:0] base;     // live tags surviving this cycle's resolve
   logic [B_MASK_WIDTH-1:0] acc;      // tags granted to older slots this cycle
   logic                    blocked;
   logic                    found;
   logic                    stall;

   // Slot walk: tag grant, dispatch prefix, dependency masks and entry fields.
   always_comb begin
      dispatch_ok_o       = '0;
      alloc_tag_o         = '0;
      inst_b_mask_o       = '0;
      entry_write_o       = '0;
      entry_b_m_o         = '0;
      entry_PC_o          = '0;
      entry_recovery_PC_o = '0;
      entry_rob_tail_o    = '0;
      entry_is_jump_o     = '0;
      // Pool excludes tags freed this cycle so a freed entry is never
      // written and cleared in the same cycle.
      pool    = ~b_mask_q;
      base    = b_mask_q & ~resolve_mask_i;
      acc     = '0;
      blocked = 1'b0;
      found   = 1'b0;
      stall   = 1'b0;

      for (int unsigned s = 0; s < DISPATCH_WIDTH; s++) begin
         if (restore_valid_i || reset) begin
            dispatch_ok_o[s] = 1'b0;
         end else if (dispatch_valid_i[s] && !blocked) begin
            if (dispatch_is_branch_i[s]) begin
               found = 1'b0;
               for (int unsigned t = 0; t < B_MASK_WIDTH; t++) begin
                  if (!found && pool[t]) begin
                     alloc_tag_o[s][t] = 1'b1;
                     found             = 1'b1;
                  end
               end
               if (found) begin
                  dispatch_ok_o[s] = 1'b1;
                  pool             = pool & ~alloc_tag_o[s];
               end else begin
                  blocked = 1'b1;
                  stall   = 1'b1;
               end
            end else begin
               dispatch_ok_o[s] = 1'b1;
            end
         end else if (dispatch_valid_i[s] && dispatch_is_branch_i[s]) begin
            stall = 1'b1;
         end

         if (dispatch_ok_o[s]) begin
            inst_b_mask_o[s] = base | acc;
         end
         acc = acc | alloc_tag_o[s];

         for (int unsigned t = 0; t < B_MASK_WIDTH; t++) begin
            if (alloc_tag_o[s][t]) begin
               entry_write_o[t]       = 1'b1;
               entry_b_m_o[t]         = inst_b_mask_o[s];
               entry_PC_o[t]          = dispatch_PC_i[s];
               entry_recovery_PC_o[t] = dispatch_recovery_PC_i[s];
               entry_rob_tail_o[t]    = dispatch_rob_tail_i[s];
               entry_is_jump_o[t]     = dispatch_is_jump_i[s];
            end
         end
      end

      if (restore_valid_i) begin
         next_b_mask_o = surviving_mask_i & ~resolve_mask_i;
      end else begin
         next_b_mask_o = base | acc;
      end
   end

   // Next-state values and free-tag popcount.
   always_comb begin
      b_mask_d    = next_b_mask_o;
      stall_cnt_d = stall_cnt_q;
      if (stall && (stall_cnt_q != '1)) begin
         stall_cnt_d = stall_cnt_q + 32'd1;
      end
      free_tag_count_o = '0;
      for (int unsigned t = 0; t < B_MASK_WIDTH; t++) begin
         if (!b_mask_q[t]) begin
            free_tag_count_o = free_tag_count_o + CNT_BITS'(1);
         end
      end
      full_stall_cycles_o = stall_cnt_q;
   end

   // Live-tag set and stall counter registers.
   always_ff @(posedge clock) begin
      if (reset) begin
         b_mask_q    <= '0;
         stall_cnt_q <= '0;
      end else begin
         b_mask_q    <= b_mask_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

endmodule
